mcpu_ctrl: RTL and testbench

MCPU_CTRL -- requirements
Module: mcpu_ctrl

---
 rtl/mcpu_pkg.sv | 61 ++++++
 rtl/mcpu_ctrl.sv | 143 ++++++++++++++
 tb/tb_mcpu_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, opcodes,
// ALU/PC select codes and the bundle of control outputs.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mcpu_ctrl.sv
// Multicycle CPU main controller: one state register, next-state logic and
// Moore output decode (FETCH write enables gated by mem_ready).
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           ir_write,
    output logic           reg_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           iord,
    output logic           mem_to_reg,
    output logic           reg_dst,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_source,
    output logic           illegal_op,
    output logic [SW-1:0]  state_o
);

    state_t state, nxt;
    ctrl_t  c, co;
    logic   illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= nxt;
    end

    always_comb begin
        nxt     = S_FETCH;
        illegal = 1'b0;
        case (state)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem_op(opcode))        nxt = S_MEMADR;
                else if (opcode == OP_RTYPE)  nxt = S_EXEC;
                else if (opcode == OP_BEQ)    nxt = S_BRANCH;
                else if (opcode == OP_J)      nxt = S_JUMP;
                else if (opcode == OP_ADDI)   nxt = S_ADDIEX;
                else                          illegal = 1'b1;
            end
            S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_RWB;
            S_RWB:    nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_ADDIEX: nxt = S_ADDIWB;
            S_ADDIWB: nxt = S_FETCH;
            default:  nxt = S_FETCH;
        endcase
    end

    always_comb begin
        c = '0;
        case (state)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PC_ALU;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                c.alu_src_b  = SRCB_BOFS;
                c.alu_op     = ALU_ADD;
                c.illegal_op = illegal;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_JUMP;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            default:  c = '0;
        endcase
    end

    // Reset state is FETCH, which would otherwise assert mem_read; blank everything while held.
    assign co = rst_n ? c : '0;

    assign pc_write      = co.pc_write;
    assign pc_write_cond = co.pc_write_cond;
    assign ir_write      = co.ir_write;
    assign reg_write     = co.reg_write;
    assign mem_read      = co.mem_read;
    assign mem_write     = co.mem_write;
    assign iord          = co.iord;
    assign mem_to_reg    = co.mem_to_reg;
    assign reg_dst       = co.reg_dst;
    assign alu_src_a     = co.alu_src_a;
    assign alu_src_b     = co.alu_src_b;
    assign alu_op        = co.alu_op;
    assign pc_source     = co.pc_source;
    assign illegal_op    = co.illegal_op;
    assign state_o       = SW'(state);

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Scoreboard bench for mcpu_ctrl: directed per-cycle vectors push expected
// {state, outputs}; a monitor pops and compares mid-cycle.
module tb_mcpu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, reg_write;
    logic       mem_read, mem_write, iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
    logic [3:0] state_o;

    mcpu_ctrl #(.OPW(6), .SW(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Output vector order: pcw pcwc irw rw mrd mwr iord m2r rdst asa asb[2] aop[2] pcs[2] ill
    localparam logic [16:0] O_ZERO     = 17'b0;
    localparam logic [16:0] O_FETCH_R  = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_FETCH_W  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [16:0] O_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_MEMRD    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_MEMWB    = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_MEMWR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_EXEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [16:0] O_RWB      = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_BRANCH   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [16:0] O_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [16:0] O_ADDIEX   = O_MEMADR;
    localparam logic [16:0] O_ADDIWB   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};

    localparam logic [5:0] LW = 6'b100011, SWO = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] o;
        logic        ar;
    } vec_t;

    vec_t        vecs[$];
    logic [20:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    event        sample_now;

    task automatic add(input logic r, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [16:0] o, input logic ar = 1'b0);
        vec_t v;
        v.rst = r; v.op = op; v.mr = mr; v.st = st; v.o = o; v.ar = ar;
        vecs.push_back(v);
    endtask

    initial begin
        logic [20:0] act, exp;
        forever begin
            @(negedge clk or sample_now);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {state_o, pc_write, pc_write_cond, ir_write, reg_write, mem_read,
                       mem_write, iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b,
                       alu_op, pc_source, illegal_op};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL ctrl t=%0t state/outputs got=%b want=%b", $time, act, exp);
                end
                checks++;
                if (mem_read && mem_write) begin
                    failures++;
                    $display("FAIL rd_wr_excl t=%0t mem_read=%b mem_write=%b want not both 1",
                             $time, mem_read, mem_write);
                end
            end
        end
    end

    initial begin
        // reset held
        add(0, LW, 0, 0, O_ZERO);
        add(0, LW, 1, 0, O_ZERO);
        // lw, mem_ready=1: 0,1,2,3,4
        add(1, LW, 1, 0, O_FETCH_R);
        add(1, LW, 1, 1, O_DECODE);
        add(1, LW, 1, 2, O_MEMADR);
        add(1, LW, 1, 3, O_MEMRD);
        add(1, LW, 1, 4, O_MEMWB);
        // sw with fetch stall 2 cycles, then 3 wait cycles in MEMWR
        add(1, SWO, 0, 0, O_FETCH_W);
        add(1, SWO, 0, 0, O_FETCH_W);
        add(1, SWO, 1, 0, O_FETCH_R);
        add(1, SWO, 1, 1, O_DECODE);
        add(1, SWO, 0, 2, O_MEMADR);
        add(1, SWO, 0, 5, O_MEMWR);
        add(1, SWO, 0, 5, O_MEMWR);
        add(1, SWO, 0, 5, O_MEMWR);
        add(1, SWO, 1, 5, O_MEMWR);
        // R-type
        add(1, RT, 1, 0, O_FETCH_R);
        add(1, RT, 1, 1, O_DECODE);
        add(1, RT, 1, 6, O_EXEC);
        add(1, RT, 1, 7, O_RWB);
        // beq
        add(1, BEQ, 1, 0, O_FETCH_R);
        add(1, BEQ, 1, 1, O_DECODE);
        add(1, BEQ, 1, 8, O_BRANCH);
        // j
        add(1, JMP, 1, 0, O_FETCH_R);
        add(1, JMP, 1, 1, O_DECODE);
        add(1, JMP, 1, 9, O_JUMP);
        // addi; opcode garbage after DECODE must be ignored
        add(1, ADDI, 1, 0, O_FETCH_R);
        add(1, ADDI, 1, 1, O_DECODE);
        add(1, BAD, 1, 10, O_ADDIEX);
        add(1, BAD, 1, 11, O_ADDIWB);
        // illegal opcode
        add(1, BAD, 1, 0, O_FETCH_R);
        add(1, BAD, 1, 1, O_DEC_ILL);
        // lw stalled in MEMRD, async reset mid-cycle
        add(1, LW, 1, 0, O_FETCH_R);
        add(1, LW, 1, 1, O_DECODE);
        add(1, LW, 1, 2, O_MEMADR);
        add(1, LW, 0, 3, O_MEMRD, 1'b1);
        add(0, LW, 1, 0, O_ZERO);
        add(0, LW, 1, 0, O_ZERO);
        // recovery: first FETCH gated by mem_ready
        add(1, JMP, 0, 0, O_FETCH_W);
        add(1, JMP, 1, 0, O_FETCH_R);
        add(1, JMP, 1, 1, O_DECODE);
        add(1, JMP, 1, 9, O_JUMP);
        add(1, JMP, 0, 0, O_FETCH_W);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst_n     = vecs[i].rst;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].mr;
            exp_q.push_back({vecs[i].st, vecs[i].o});
            if (vecs[i].ar) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                exp_q.push_back({4'd0, O_ZERO});
                ->sample_now;
            end
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
